// File: rtl/pipeline_debug_ctrl.sv
// Debug-unit sequencer: turns a UART byte command stream into instruction-memory loads,
// run/step control of the pipeline, and a byte-serial dump of PC, cycles, registers and memory.
module pipeline_debug_ctrl #(
  parameter int                  NB_DATA     = 32,
  parameter int                  NB_BYTE     = 8,
  parameter int                  ADDR_WIDTH  = 7,
  parameter int                  NB_REG      = 5,
  parameter int                  N_REGS      = 32,
  parameter int                  N_MEM_WORDS = 32,
  parameter logic [NB_DATA-1:0]  HALT_WORD   = 32'hFC000000
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  input  logic                  i_halt,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [ADDR_WIDTH-1:0] i_count_cycles,
  input  logic [NB_DATA-1:0]    i_reg_data,
  input  logic [NB_DATA-1:0]    i_mem_data,
  output logic                  o_debug_unit,
  output logic [NB_DATA-1:0]    o_inst_load,
  output logic [ADDR_WIDTH-1:0] o_addr_inst_load,
  output logic                  o_en_write,
  output logic                  o_enable_pipe,
  output logic                  o_en_read,
  output logic [NB_REG-1:0]     o_addr_debug_unit,
  output logic [ADDR_WIDTH-1:0] o_addr_mem_debug_unit,
  output logic                  o_ctrl_read_debug_reg,
  output logic                  o_ctrl_addr_debug_mem
);

  localparam int N_WORDS = 2 + N_REGS + N_MEM_WORDS;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam int BPW     = NB_DATA / NB_BYTE;
  localparam int BCNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int REST_W  = NB_DATA - NB_BYTE;

  localparam logic [NB_BYTE-1:0]    CMD_LOAD  = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0]    CMD_RUN   = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0]    CMD_STEP  = NB_BYTE'(8'h53);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [BCNT_W-1:0]     LAST_BYTE = BCNT_W'(BPW - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0]      REG_BASE  = IDX_W'(2);
  localparam logic [IDX_W-1:0]      MEM_BASE  = IDX_W'(2 + N_REGS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RUN     = 3'd3,
    ST_STEP    = 3'd4,
    ST_DUMP_RD = 3'd5,
    ST_DUMP_TX = 3'd6
  } state_t;

  state_t              state_r;
  logic [REST_W-1:0]   word_r;
  logic [BCNT_W-1:0]   byte_cnt_r;
  logic                halted_r;
  logic [IDX_W-1:0]    dump_idx_r;
  logic                rd_wait_r;
  logic [REST_W-1:0]   tx_rest_r;

  logic [NB_DATA-1:0]  load_word_s;
  logic [NB_DATA-1:0]  cap_word_s;
  logic [IDX_W-1:0]    nxt_idx_s;
  logic [IDX_W-1:0]    reg_off_s;
  logic [IDX_W-1:0]    mem_off_s;
  logic                nxt_is_reg_s;
  logic                nxt_is_mem_s;

  // Incoming instruction bytes are shifted in MSB first; the 4th byte completes the word.
  assign load_word_s = {word_r, i_rx_data};

  // Word source for the dump slot currently being read, and address decode of the next slot.
  always_comb begin
    cap_word_s   = i_mem_data;
    nxt_idx_s    = dump_idx_r + IDX_W'(1);
    reg_off_s    = nxt_idx_s - REG_BASE;
    mem_off_s    = nxt_idx_s - MEM_BASE;
    nxt_is_reg_s = (nxt_idx_s >= REG_BASE) && (nxt_idx_s < MEM_BASE);
    nxt_is_mem_s = (nxt_idx_s >= MEM_BASE);
    if (dump_idx_r == IDX_W'(0)) begin
      cap_word_s = NB_DATA'(i_pc);
    end else if (dump_idx_r == IDX_W'(1)) begin
      cap_word_s = NB_DATA'(i_count_cycles);
    end else if (o_ctrl_read_debug_reg) begin
      cap_word_s = i_reg_data;
    end else begin
      cap_word_s = i_mem_data;
    end
  end

  // Sequencer FSM with every pipeline/UART control output registered.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r               <= ST_IDLE;
      word_r                <= '0;
      byte_cnt_r            <= '0;
      halted_r              <= 1'b0;
      dump_idx_r            <= '0;
      rd_wait_r             <= 1'b0;
      tx_rest_r             <= '0;
      o_tx_data             <= '0;
      o_tx_valid            <= 1'b0;
      o_debug_unit          <= 1'b0;
      o_inst_load           <= '0;
      o_addr_inst_load      <= '0;
      o_en_write            <= 1'b0;
      o_enable_pipe         <= 1'b0;
      o_en_read             <= 1'b0;
      o_addr_debug_unit     <= '0;
      o_addr_mem_debug_unit <= '0;
      o_ctrl_read_debug_reg <= 1'b0;
      o_ctrl_addr_debug_mem <= 1'b0;
    end else begin
      o_en_write <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              state_r          <= ST_LOAD;
              o_debug_unit     <= 1'b1;
              o_addr_inst_load <= '0;
              halted_r         <= 1'b0;
              byte_cnt_r       <= '0;
            end else if (i_rx_data == CMD_RUN) begin
              state_r       <= ST_RUN;
              o_enable_pipe <= ~halted_r;
              o_en_read     <= ~halted_r;
            end else if (i_rx_data == CMD_STEP) begin
              state_r       <= ST_STEP;
              o_enable_pipe <= ~halted_r;
              o_en_read     <= ~halted_r;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end

        ST_LOAD: begin
          if (i_rx_valid) begin
            word_r <= load_word_s[REST_W-1:0];
            if (byte_cnt_r == LAST_BYTE) begin
              byte_cnt_r  <= '0;
              o_inst_load <= load_word_s;
              o_en_write  <= 1'b1;
              state_r     <= ST_WRITE;
            end else begin
              byte_cnt_r <= byte_cnt_r + BCNT_W'(1);
            end
          end
        end

        ST_WRITE: begin
          if ((o_inst_load == HALT_WORD) || (o_addr_inst_load == LAST_ADDR)) begin
            o_debug_unit <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            o_addr_inst_load <= o_addr_inst_load + ADDR_WIDTH'(1);
            state_r          <= ST_LOAD;
          end
        end

        ST_RUN: begin
          if (halted_r) begin
            dump_idx_r <= '0;
            rd_wait_r  <= 1'b0;
            state_r    <= ST_DUMP_RD;
          end else if (i_halt) begin
            o_enable_pipe <= 1'b0;
            o_en_read     <= 1'b0;
            halted_r      <= 1'b1;
            dump_idx_r    <= '0;
            rd_wait_r     <= 1'b0;
            state_r       <= ST_DUMP_RD;
          end
        end

        ST_STEP: begin
          // The pulse was issued on entry only when not halted, so o_enable_pipe marks it.
          if (o_enable_pipe && i_halt) begin
            halted_r <= 1'b1;
          end
          o_enable_pipe <= 1'b0;
          o_en_read     <= 1'b0;
          dump_idx_r    <= '0;
          rd_wait_r     <= 1'b0;
          state_r       <= ST_DUMP_RD;
        end

        ST_DUMP_RD: begin
          if (!rd_wait_r) begin
            rd_wait_r <= 1'b1;
          end else begin
            tx_rest_r             <= cap_word_s[REST_W-1:0];
            o_tx_data             <= cap_word_s[NB_DATA-1 -: NB_BYTE];
            o_tx_valid            <= 1'b1;
            byte_cnt_r            <= '0;
            o_ctrl_read_debug_reg <= 1'b0;
            o_ctrl_addr_debug_mem <= 1'b0;
            state_r               <= ST_DUMP_TX;
          end
        end

        ST_DUMP_TX: begin
          if (i_tx_ready) begin
            if (byte_cnt_r == LAST_BYTE) begin
              o_tx_valid <= 1'b0;
              byte_cnt_r <= '0;
              if (dump_idx_r == LAST_IDX) begin
                state_r <= ST_IDLE;
              end else begin
                dump_idx_r            <= nxt_idx_s;
                rd_wait_r             <= 1'b0;
                o_ctrl_read_debug_reg <= nxt_is_reg_s;
                o_ctrl_addr_debug_mem <= nxt_is_mem_s;
                if (nxt_is_reg_s) begin
                  o_addr_debug_unit <= NB_REG'(reg_off_s);
                end
                if (nxt_is_mem_s) begin
                  o_addr_mem_debug_unit <= ADDR_WIDTH'(mem_off_s);
                end
                state_r <= ST_DUMP_RD;
              end
            end else begin
              byte_cnt_r <= byte_cnt_r + BCNT_W'(1);
              o_tx_data  <= tx_rest_r[REST_W-1 -: NB_BYTE];
              tx_rest_r  <= {tx_rest_r[REST_W-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
            end
          end
        end

        default: begin
          o_enable_pipe         <= 1'b0;
          o_en_read             <= 1'b0;
          o_tx_valid            <= 1'b0;
          o_ctrl_read_debug_reg <= 1'b0;
          o_ctrl_addr_debug_mem <= 1'b0;
          state_r               <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: a queue-based model of expected writes and dump
// bytes is checked every cycle, with literal expectations pinning the key values.
module tb_pipeline_debug_ctrl;

  logic        clock = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        i_halt;
  logic [6:0]  i_pc;
  logic [6:0]  i_count_cycles;
  logic [31:0] i_reg_data;
  logic [31:0] i_mem_data;
  logic        o_debug_unit;
  logic [31:0] o_inst_load;
  logic [6:0]  o_addr_inst_load;
  logic        o_en_write;
  logic        o_enable_pipe;
  logic        o_en_read;
  logic [4:0]  o_addr_debug_unit;
  logic [6:0]  o_addr_mem_debug_unit;
  logic        o_ctrl_read_debug_reg;
  logic        o_ctrl_addr_debug_mem;

  always #5 clock = ~clock;

  pipeline_debug_ctrl dut (
    .clock                 (clock),
    .i_reset               (i_reset),
    .i_rx_data             (i_rx_data),
    .i_rx_valid            (i_rx_valid),
    .o_tx_data             (o_tx_data),
    .o_tx_valid            (o_tx_valid),
    .i_tx_ready            (i_tx_ready),
    .i_halt                (i_halt),
    .i_pc                  (i_pc),
    .i_count_cycles        (i_count_cycles),
    .i_reg_data            (i_reg_data),
    .i_mem_data            (i_mem_data),
    .o_debug_unit          (o_debug_unit),
    .o_inst_load           (o_inst_load),
    .o_addr_inst_load      (o_addr_inst_load),
    .o_en_write            (o_en_write),
    .o_enable_pipe         (o_enable_pipe),
    .o_en_read             (o_en_read),
    .o_addr_debug_unit     (o_addr_debug_unit),
    .o_addr_mem_debug_unit (o_addr_mem_debug_unit),
    .o_ctrl_read_debug_reg (o_ctrl_read_debug_reg),
    .o_ctrl_addr_debug_mem (o_ctrl_addr_debug_mem)
  );

  // Pipeline-side register file and data memory, one-cycle read latency.
  logic [31:0] regs_m [0:31];
  logic [31:0] mem_m  [0:127];
  logic [31:0] reg_rd, mem_rd;
  always @(posedge clock) begin
    reg_rd <= regs_m[o_addr_debug_unit];
    mem_rd <= mem_m[o_addr_mem_debug_unit];
  end
  assign i_reg_data = reg_rd;
  assign i_mem_data = mem_rd;

  logic [31:0] exp_wr_word [$];
  logic [6:0]  exp_wr_addr [$];
  logic [7:0]  exp_tx [$];
  logic [7:0]  rx_log [0:2047];
  int vectors = 0;
  int errors = 0;
  int tx_count = 0;
  int pulse_cnt = 0;
  int run_len = 0;
  int last_len = 0;
  int cyc = 0;
  logic stall_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {o_tx_data, o_tx_valid, o_debug_unit, o_inst_load, o_addr_inst_load, o_en_write,
            o_enable_pipe, o_en_read, o_addr_debug_unit, o_addr_mem_debug_unit,
            o_ctrl_read_debug_reg, o_ctrl_addr_debug_mem};
  endfunction

  task automatic push_word_bytes(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_tx.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_dump();
    push_word_bytes({25'd0, i_pc});
    push_word_bytes({25'd0, i_count_cycles});
    for (int r = 0; r < 32; r++) push_word_bytes(regs_m[r]);
    for (int m = 0; m < 32; m++) push_word_bytes(mem_m[m]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clock); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [6:0] addr, input logic [31:0] w);
    exp_wr_addr.push_back(addr);
    exp_wr_word.push_back(w);
    for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
  endtask

  task automatic wait_dump_done(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || o_tx_valid) && n < 4000) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 4000) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: got %0d bytes outstanding expected 0", name, exp_tx.size());
    end
  endtask

  // Transmit-ready driver: always ready, or ready one cycle in three.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      cyc++;
      i_tx_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Per-cycle compare against the expected write and byte queues.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clock);
      if (i_reset) begin
        if (prev_stall) begin
          check("tx_hold_valid", o_tx_valid, 1'b1);
          check("tx_hold_data", o_tx_data, prev_data);
        end
        check("sel_exclusive", o_ctrl_read_debug_reg & o_ctrl_addr_debug_mem, 1'b0);
        if (o_en_write) begin
          if (exp_wr_word.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_write: got write of %0h at %0h expected none",
                     o_inst_load, o_addr_inst_load);
          end else begin
            check("wr_addr", o_addr_inst_load, exp_wr_addr.pop_front());
            check("wr_word", o_inst_load, exp_wr_word.pop_front());
            check("wr_debug_unit", o_debug_unit, 1'b1);
          end
        end
        if (o_tx_valid && i_tx_ready) begin
          if (exp_tx.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_tx: got byte %0h expected none", o_tx_data);
          end else begin
            check("tx_byte", o_tx_data, exp_tx.pop_front());
          end
          if (tx_count < 2048) rx_log[tx_count] = o_tx_data;
          tx_count++;
        end
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
        if (o_enable_pipe) begin
          run_len++;
        end else if (run_len > 0) begin
          last_len = run_len;
          pulse_cnt++;
          run_len = 0;
        end
      end else begin
        prev_stall = 1'b0;
        run_len    = 0;
      end
    end
  end

  initial begin
    int base;
    int p0;
    int n;
    i_reset        = 1'b0;
    i_rx_data      = 8'h00;
    i_rx_valid     = 1'b0;
    i_halt         = 1'b0;
    i_pc           = 7'd9;
    i_count_cycles = 7'd11;
    for (int r = 0; r < 32; r++) regs_m[r] = 32'hA5000000 ^ (r * 32'h00010203);
    for (int m = 0; m < 128; m++) mem_m[m] = 32'h5A000000 + m * 32'h00000111;
    #1;
    check("reset_outputs", all_outs(), 128'd0);
    repeat (3) @(posedge clock);
    @(negedge clock) i_reset = 1'b1;

    // Load three words ending with the halt word.
    send_byte(8'h4C);
    send_word(7'd0, 32'h3C01000A);
    send_word(7'd1, 32'h3C020014);
    send_word(7'd2, 32'hFC000000);
    check("t1_write_strobe", o_en_write, 1'b1);
    check("t1_debug_during_write", o_debug_unit, 1'b1);
    @(posedge clock); #1;
    check("t1_debug_unit_off", o_debug_unit, 1'b0);
    check("t1_writes_left", exp_wr_word.size(), 0);

    // Run until halt raised 10 cycles after enable.
    base = tx_count;
    p0   = pulse_cnt;
    push_dump();
    send_byte(8'h52);
    check("t2_enable_latency", o_enable_pipe, 1'b1);
    check("t2_en_read", o_en_read, 1'b1);
    repeat (10) begin @(posedge clock); #1; end
    i_halt = 1'b1;
    wait_dump_done("t2");
    i_halt = 1'b0;
    check("t2_pulse_len", last_len, 11);
    check("t2_pulse_count", pulse_cnt - p0, 1);
    check("t2_byte_count", tx_count - base, 264);
    check("t2_first_word", {rx_log[base], rx_log[base+1], rx_log[base+2], rx_log[base+3]},
          32'h00000009);
    check("t2_second_word", {rx_log[base+4], rx_log[base+5], rx_log[base+6], rx_log[base+7]},
          32'h0000000B);

    // Fill all 128 addresses without a halt word, then stray bytes must not write.
    send_byte(8'h4C);
    for (int a = 0; a < 128; a++) send_word(7'(a), 32'h20000000 | a);
    @(posedge clock); #1;
    check("t6_debug_unit_off", o_debug_unit, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'h11);
    repeat (3) @(posedge clock);
    check("t6_writes_left", exp_wr_word.size(), 0);
    check("t6_debug_unit_idle", o_debug_unit, 1'b0);

    // Two steps before halt, the second one seeing i_halt.
    for (int s = 0; s < 2; s++) begin
      p0 = pulse_cnt;
      base = tx_count;
      i_halt = (s == 1);
      push_dump();
      send_byte(8'h53);
      check("t4_step_pulse", o_enable_pipe, 1'b1);
      wait_dump_done("t4");
      check("t4_pulse_len", last_len, 1);
      check("t4_pulse_count", pulse_cnt - p0, 1);
      check("t4_byte_count", tx_count - base, 264);
    end
    i_halt = 1'b0;

    // Step after halt: dump only, with the transmitter ready one cycle in three.
    i_pc = 7'h13;
    stall_mode = 1'b1;
    p0 = pulse_cnt;
    base = tx_count;
    push_dump();
    send_byte(8'h53);
    check("t3_no_pulse", o_enable_pipe, 1'b0);
    wait_dump_done("t3");
    stall_mode = 1'b0;
    check("t3_pulse_count", pulse_cnt - p0, 0);
    check("t3_byte_count", tx_count - base, 264);
    check("t3_first_word", {rx_log[base], rx_log[base+1], rx_log[base+2], rx_log[base+3]},
          32'h00000013);

    // Asynchronous reset at the 100th dumped byte.
    base = tx_count;
    push_dump();
    send_byte(8'h53);
    n = 0;
    while (tx_count - base < 100 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check("t5_reached_100", tx_count - base, 100);
    #2 i_reset = 1'b0;
    #1 check("t5_async_reset_outputs", all_outs(), 128'd0);
    exp_tx.delete();
    repeat (2) @(posedge clock);
    @(negedge clock) i_reset = 1'b1;
    i_pc           = 7'h2A;
    i_count_cycles = 7'h55;
    base = tx_count;
    p0   = pulse_cnt;
    push_dump();
    send_byte(8'h52);
    check("t5_run_after_reset", o_enable_pipe, 1'b1);
    repeat (3) begin @(posedge clock); #1; end
    i_halt = 1'b1;
    wait_dump_done("t5");
    i_halt = 1'b0;
    check("t5_pulse_len", last_len, 4);
    check("t5_pulse_count", pulse_cnt - p0, 1);
    check("t5_byte_count", tx_count - base, 264);
    check("t5_first_word", {rx_log[base], rx_log[base+1], rx_log[base+2], rx_log[base+3]},
          32'h0000002A);
    check("t5_second_word", {rx_log[base+4], rx_log[base+5], rx_log[base+6], rx_log[base+7]},
          32'h00000055);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
